// File: rtl/modexp_datapath.sv
// Operand front end and multiply/reduce datapath for the modular-exponentiation engine.
// Holds the operands, steps acc = acc * base mod m under controller strobes, and keeps the result until acknowledged.
module modexp_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_base,
    input  logic [WIDTH-1:0] in_exp,
    input  logic [WIDTH-1:0] in_mod,
    output logic             input_data_ready,
    input  logic             initialize,
    input  logic             en_multiply,
    input  logic             en_modulo,
    input  logic             done,
    output logic             is_multiplication_done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             result_err,
    input  logic             result_ack
);

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        RUN,
        HOLD
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   base_r;
    logic [WIDTH-1:0]   exp_r;
    logic [WIDTH-1:0]   mod_r;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic               mod_zero;
    logic               mod_gt_one;

    assign mod_zero   = (mod_r == '0);
    assign mod_gt_one = (mod_r > WIDTH'(1));

    assign in_ready         = (state == IDLE);
    assign input_data_ready = (state == LOADED);

    // A zero modulus has nothing to iterate, so the controller is released immediately.
    assign is_multiplication_done = (state == RUN) && (mod_zero || (cnt == exp_r));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base_r       <= '0;
            exp_r        <= '0;
            mod_r        <= '0;
            acc          <= '0;
            cnt          <= '0;
            prod         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            result_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        base_r     <= in_base;
                        exp_r      <= in_exp;
                        mod_r      <= in_mod;
                        result_err <= 1'b0;
                        state      <= LOADED;
                    end
                end

                LOADED: begin
                    if (initialize) begin
                        // Pre-reducing the base keeps every product below mod^2, so 2*WIDTH bits are exact.
                        if (!mod_zero) begin
                            base_r <= base_r % mod_r;
                        end
                        acc        <= {{(WIDTH-1){1'b0}}, mod_gt_one};
                        cnt        <= '0;
                        result_err <= mod_zero;
                        state      <= RUN;
                    end
                end

                RUN: begin
                    if (en_multiply) begin
                        prod <= {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, base_r};
                    end else if (en_modulo) begin
                        if (!mod_zero) begin
                            acc <= WIDTH'(prod % {{WIDTH{1'b0}}, mod_r});
                        end
                        cnt <= cnt + WIDTH'(1);
                    end

                    if (done && is_multiplication_done) begin
                        result       <= acc;
                        result_valid <= 1'b1;
                        state        <= HOLD;
                    end
                end

                HOLD: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
